alu_flag_stage: RTL
===================

# alu_flag_stage

Execute-stage back end sitting directly downstream of the 64-bit `alu`. It accepts each ALU result with its N/Z/V/C outputs through a valid/ready handshake and holds the architectural NZCV flag register. It resolves branches (B.cond, CBZ, CBNZ, B) and passes result, destination and taken bit to writeback through a 2-entry skid buffer, so writeback stalls never create a combinational path back into the ALU.

## Interface
- `WIDTH`, 64, datapath width; must match `alu`.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents an ALU result.
- `in_ready`  out  1  stage can accept this cycle; registered.
- `in_result`  in  WIDTH  ALU `result`.
- `in_negative`, `in_zero`, `in_overflow`, `in_carry_out`  in  1 each  ALU flag outputs.
- `in_setflags`  in  1  instruction writes NZCV (ADDS/SUBS/ANDS).
- `in_arith`  in  1  ALU op was ADD/SUBTRACT; otherwise V and C are not meaningful.
- `in_br_op`  in  3  branch kind, `br_op_t`: NONE=0, BCOND=1, CBZ=2, CBNZ=3, B=4.
- `in_cond`  in  4  condition code for BCOND.
- `in_rd`  in  5  destination register.
- `in_regwrite`  in  1  writeback enable.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  writeback consumes head.
- `out_result`  out  WIDTH, `out_rd` out 5, `out_regwrite` out 1, `out_taken` out 1  head entry fields.
- `flags_q`  out  4  architectural {N,Z,C,V}.

## Operation
- Accept = `in_valid && in_ready`. Drain = `out_valid && out_ready`.
- On accept with `in_setflags`: N←in_negative, Z←in_zero. If `in_arith`, C←in_carry_out and V←in_overflow; otherwise C←0 and V←0. Without `in_setflags`, flags are unchanged.
- `out_taken` is computed at accept time from `flags_q` *before* this instruction's own update. This flag state includes every earlier accepted instruction.
  - NONE→0; B→1; CBZ→`in_zero`; CBNZ→`!in_zero`.
  - BCOND: EQ 0:Z, NE 1:!Z, HS 2:C, LO 3:!C, MI 4:N, PL 5:!N, VS 6:V, VC 7:!V, HI 8:C&!Z, LS 9:!(C&!Z), GE 10:N==V, LT 11:N!=V, GT 12:!Z&(N==V), LE 13:!(GT), AL 14/15:1.
  - Undefined `in_br_op` codes 5–7 are treated as NONE.
- Buffer: 2 entries, FIFO order, occupancy count 0..2. `out_*` come from the head entry. Output fields hold stable while `out_valid && !out_ready`.
- Count behaviour:
  - Accept only: count+1.
  - Drain only: count−1.
  - Both: count unchanged, and the new entry goes behind the remaining one. At count 1 the new entry becomes the head next cycle.
  - Accept at count 2 cannot occur.
- `in_ready` next = (count_next != 2).

## Timing
- Reset (async assert, synchronous release):
  - `in_ready`=0, `out_valid`=0, count=0, `flags_q`=4'b0000.
  - `out_result`=0, `out_rd`=0, `out_regwrite`=0, `out_taken`=0.
  - `in_ready` rises on the first clock edge after `reset_n` deasserts.
- Latency: an instruction accepted at edge N appears at `out_valid` after edge N; the `flags_q` update is visible after edge N.
- Throughput: 1 per cycle while `out_ready` is held high.
- `in_ready` depends only on registered state; there is no path from `out_ready` to `in_ready`.
- Reset mid-operation: buffered entries are discarded and flags are cleared; no partial drain.
- Upstream may drop `in_valid` without acceptance; no data is captured in that case.

## Structure
- `alu_pkg` holds:
  - the ALU `cntrl` constants (PASS_B 000, ADD 010, SUBTRACT 011, AND 100, OR 101, XOR 110);
  - `br_op_t`;
  - the condition-code constants `COND_EQ`..`COND_AL`.
- Sub-module `cond_eval`: purely combinational; inputs flags, `in_br_op`, `in_cond`, `in_zero`; output taken. It is verified standalone over all 16 conditions × 16 flag combinations.
- Buffer and flag register live in `alu_flag_stage`; no separate FIFO module.

## Test plan
- Reset then idle:
  - all outputs 0 while `reset_n`=0;
  - `in_ready`=1 one edge after release;
  - `flags_q`=0000.
- SUBS setflags:
  - input: result 0, Z=1, C=1, V=0, arith;
  - expect `flags_q`=0110 next cycle.
  - A following BCOND EQ → `out_taken`=1; BCOND NE → 0.
- ANDS flag clearing:
  - input: setflags, non-arith, N=1, `in_overflow`=1, `in_carry_out`=1;
  - expect `flags_q`=1000.
- CBZ/CBNZ:
  - `in_zero`=1 with CBZ → taken 1; CBNZ → taken 0;
  - `flags_q` unchanged.
- Backpressure:
  - hold `out_ready`=0 and push 3 valid entries;
  - expect first two accepted, `in_ready`=0 after the second, `out_*` stable;
  - release → drain in order with values preserved.
- Streaming: `out_ready`=1, 100 back-to-back random entries → one output per cycle, order preserved, `in_ready` never deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, branch kinds and condition codes
package alu_pkg;

    localparam logic [2:0] CNTRL_PASS_B   = 3'b000;
    localparam logic [2:0] CNTRL_ADD      = 3'b010;
    localparam logic [2:0] CNTRL_SUBTRACT = 3'b011;
    localparam logic [2:0] CNTRL_AND      = 3'b100;
    localparam logic [2:0] CNTRL_OR       = 3'b101;
    localparam logic [2:0] CNTRL_XOR      = 3'b110;

    typedef enum logic [2:0] {
        BR_NONE  = 3'd0,
        BR_BCOND = 3'd1,
        BR_CBZ   = 3'd2,
        BR_CBNZ  = 3'd3,
        BR_B     = 3'd4
    } br_op_t;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_HS = 4'd2;
    localparam logic [3:0] COND_LO = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    // Bit positions inside the {N,Z,C,V} flag register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       taken;
    } entry_meta_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch resolution from NZCV flags
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [2:0] br_op_i,
    input  logic [3:0] cond_i,
    input  logic       zero_i,
    output logic       taken_o
);

    logic n, z, c, v;
    logic cond_true;
    logic hi, ge, gt;

    assign n  = flags_i[FLAG_N];
    assign z  = flags_i[FLAG_Z];
    assign c  = flags_i[FLAG_C];
    assign v  = flags_i[FLAG_V];
    assign hi = c & ~z;
    assign ge = (n == v);
    assign gt = ~z & ge;

    always_comb begin
        cond_true = 1'b1;
        case (cond_i)
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_HS: cond_true = c;
            COND_LO: cond_true = ~c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = ~n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = ~v;
            COND_HI: cond_true = hi;
            COND_LS: cond_true = ~hi;
            COND_GE: cond_true = ge;
            COND_LT: cond_true = ~ge;
            COND_GT: cond_true = gt;
            COND_LE: cond_true = ~gt;
            default: cond_true = 1'b1;
        endcase
    end

    // CBZ/CBNZ test the ALU's own zero output, not the architectural Z flag
    always_comb begin
        taken_o = 1'b0;
        case (br_op_i)
            BR_BCOND: taken_o = cond_true;
            BR_CBZ:   taken_o = zero_i;
            BR_CBNZ:  taken_o = ~zero_i;
            BR_B:     taken_o = 1'b1;
            default:  taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_stage.sv
// rtl/alu_flag_stage.sv - NZCV flag register, branch resolve and 2-entry skid buffer
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_negative,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic             in_carry_out,
    input  logic             in_setflags,
    input  logic             in_arith,
    input  logic [2:0]       in_br_op,
    input  logic [3:0]       in_cond,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_regwrite,
    output logic             out_taken,
    output logic [3:0]       flags_q
);

    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic [3:0]       flags_d;
    logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
    entry_meta_t      meta0_q, meta0_d, meta1_q, meta1_d;
    entry_meta_t      new_meta;
    logic             taken;
    logic             accept, drain;

    cond_eval u_cond_eval (
        .flags_i (flags_q),
        .br_op_i (in_br_op),
        .cond_i  (in_cond),
        .zero_i  (in_zero),
        .taken_o (taken)
    );

    assign accept    = in_valid & in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign drain     = out_valid & out_ready;

    assign new_meta.rd       = in_rd;
    assign new_meta.regwrite = in_regwrite;
    assign new_meta.taken    = taken;

    // Slot 0 is always the head; slot 1 only ever holds the second-oldest entry
    always_comb begin
        count_d = count_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        meta0_d = meta0_q;
        meta1_d = meta1_q;
        case ({accept, drain})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    res0_d  = in_result;
                    meta0_d = new_meta;
                end else begin
                    res1_d  = in_result;
                    meta1_d = new_meta;
                end
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                res0_d  = res1_q;
                meta0_d = meta1_q;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    res0_d  = in_result;
                    meta0_d = new_meta;
                end else begin
                    res0_d  = res1_q;
                    meta0_d = meta1_q;
                    res1_d  = in_result;
                    meta1_d = new_meta;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (accept && in_setflags) begin
            flags_d[FLAG_N] = in_negative;
            flags_d[FLAG_Z] = in_zero;
            flags_d[FLAG_C] = in_arith & in_carry_out;
            flags_d[FLAG_V] = in_arith & in_overflow;
        end
    end

    // Registered ready: decided from next occupancy, never from out_ready directly
    assign in_ready_d = (count_d != 2'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
            flags_q    <= 4'b0000;
            res0_q     <= '0;
            res1_q     <= '0;
            meta0_q    <= '0;
            meta1_q    <= '0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            flags_q    <= flags_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
            meta0_q    <= meta0_d;
            meta1_q    <= meta1_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_result   = res0_q;
    assign out_rd       = meta0_q.rd;
    assign out_regwrite = meta0_q.regwrite;
    assign out_taken    = meta0_q.taken;

endmodule
